dmem_bus_bridge: RTL and testbench
==================================

// Module: dmem_bus_bridge
// PURPOSE
// - MEM-stage downstream of the pipelined core: turns the per-cycle data-memory access (addr, wdata, byteEnable,
//   write/read strobes) into a valid/ready request + response bus to external data memory / MMIO.
// - Holds the pipeline (stall to hazard unit) while the bus transaction is outstanding; returns the raw aligned
//   read word to the core's load extender.
// PARAMETERS
// - TIMEOUT_CYCLES  255  cycles in REQ+WAIT before the access is abandoned (1..2^CNT_W-1)
// - CNT_W           8    timeout counter width
// PORTS
// - clk            in   1   clock, all state on rising edge
// - clr_n          in   1   reset, asynchronous, active-low
// - MemWriteM      in   1   MEM-stage store
// - MemReadM       in   1   MEM-stage load (never high together with MemWriteM)
// - ALUResultM     in   32  byte address
// - WriteDataM     in   32  store data, unshifted (lane 0 aligned)
// - byteEnable     in   4   store byte lanes, already positioned by address
// - RD_data        out  32  read word to load extender, valid in DONE
// - StallMem       out  1   to hazard unit: freeze IF..MEM, bubble WB
// - bus_req_valid  out  1   request valid
// - bus_req_ready  in   1   request accepted
// - bus_we         out  1   1 = write
// - bus_addr       out  32  {ALUResultM[31:2],2'b00}
// - bus_wdata      out  32  WriteDataM << (8*ALUResultM[1:0])
// - bus_be         out  4   byteEnable on writes, 4'b1111 on reads
// - bus_rsp_valid  in   1   response/completion strobe
// - bus_rsp_err    in   1   response carries error (qualified by bus_rsp_valid)
// - bus_rdata      in   32  read data (qualified by bus_rsp_valid)
// - mem_err        out  1   one-cycle pulse: bus error or timeout
// BEHAVIOUR
// - Reset (clr_n=0, async): state IDLE, counter 0, RD_data=0, bus_req_valid=0, bus_we=0, bus_addr/wdata=0,
//   bus_be=0, mem_err=0. Reset mid-transaction abandons it; later bus_rsp_valid is ignored.
// - FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
// - IDLE: (MemWriteM|MemReadM) -> StallMem=1 combinationally same cycle; latch addr/we/wdata/be; -> REQ.
// - REQ: bus_req_valid=1, bus_* fields held stable until bus_req_ready=1; then -> WAIT. StallMem=1.
// - WAIT: StallMem=1; bus_rsp_valid -> RD_data<=bus_rdata (0 if bus_rsp_err or write), -> DONE;
//   mem_err pulses in DONE if bus_rsp_err. bus_rsp_valid outside WAIT ignored.
// - DONE: StallMem=0 for exactly one cycle; RD_data held; the instruction in MEM completes; -> IDLE
//   unconditionally (access strobes seen in DONE belong to the completed instruction, never re-issued).
// - Min stall: 3 cycles (IDLE, REQ w/ ready, WAIT w/ rsp); DONE is the release cycle.
// - Timeout: counter clears on leaving IDLE, +1 each REQ/WAIT cycle; at TIMEOUT_CYCLES -> DONE, bus_req_valid
//   drops, RD_data=0, mem_err pulses. Counter saturates, never wraps.
// - Stores: bus_we=1, wdata lane-shifted; byte lanes with be=0 are don't-care. Loads: bus_we=0, be=4'b1111.
// - bus_req_ready and bus_rsp_valid both high in REQ: only ready consumed; rsp counted next cycle in WAIT.
// - RD_data changes only on entering DONE or reset.
// CONFIGURATION
// - DMEM_BRIDGE_POSTED_WRITE_EN defined: stores are posted; REQ+ready on a write -> DONE directly (no WAIT,
//   min stall 2 cycles); write completions ignored, write bus_rsp_err not reported. Loads unchanged.
// - Undefined: stores wait for bus_rsp_valid exactly as loads; write errors pulse mem_err.
// TESTING
// - lw addr 0x100, ready immediate, rsp next cycle rdata 0xDEADBEEF -> StallMem high 3 cycles, RD_data=0xDEADBEEF in
//   DONE, bus_be=4'b1111, bus_addr=0x100.
// - sb addr 0x203 WriteDataM=0x000000A5 be=4'b1000 -> bus_addr=0x200, bus_wdata=0xA5000000, bus_we=1.
// - ready held low 5 cycles in REQ -> bus_req_valid and all fields stable, StallMem high throughout.
// - no response, TIMEOUT_CYCLES=4 -> DONE after 4 REQ/WAIT cycles, RD_data=0, mem_err one-cycle pulse.
// - clr_n low during WAIT then late bus_rsp_valid -> IDLE, outputs zero, response ignored, no stall.
// - POSTED_WRITE_EN: sw with immediate ready -> StallMem 2 cycles; undefined: 3 cycles with rsp next cycle.

Source files
------------

// File: rtl/dmem_bus_bridge.sv
// MEM-stage data access to valid/ready bus bridge with pipeline stall.
// Optional: DMEM_BRIDGE_POSTED_WRITE_EN makes stores complete on request acceptance.
module dmem_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  byteEnable,
  output logic [31:0] RD_data,
  output logic        StallMem,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_rsp_valid,
  input  logic        bus_rsp_err,
  input  logic [31:0] bus_rdata,
  output logic        mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic             access;
  logic             expired;
  logic             posted;
  logic [31:0]      rd_nx;
  logic             err_nx;

  assign access  = MemWriteM | MemReadM;
  assign expired = (cnt >= CNT_LAST);

`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
  assign posted = bus_we;
`else
  assign posted = 1'b0;
`endif

  assign StallMem = ((state == IDLE) & access)
                  | (state == REQ)
                  | (state == WAIT);

  // Handshake beats timeout when both land on the same cycle.
  always_comb begin
    state_nx = state;
    rd_nx    = '0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) state_nx = REQ;
      end
      REQ: begin
        if (bus_req_ready) begin
          state_nx = posted ? DONE : WAIT;
        end else if (expired) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          state_nx = DONE;
          err_nx   = bus_rsp_err;
          if (!bus_rsp_err && !bus_we) begin
            rd_nx = bus_rdata;
          end
        end else if (expired) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= IDLE;
      cnt           <= '0;
      RD_data       <= '0;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_be        <= '0;
      mem_err       <= 1'b0;
    end else begin
      state   <= state_nx;
      mem_err <= 1'b0;
      if ((state == IDLE) && access) begin
        cnt           <= '0;
        bus_req_valid <= 1'b1;
        bus_we        <= MemWriteM;
        bus_addr      <= {ALUResultM[31:2], 2'b00};
        bus_wdata     <= WriteDataM
                         << {ALUResultM[1:0], 3'b000};
        bus_be        <= MemWriteM ? byteEnable : 4'b1111;
      end
      if ((state == REQ) || (state == WAIT)) begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
      if ((state == REQ) && (state_nx != REQ)) begin
        bus_req_valid <= 1'b0;
      end
      if ((state != DONE) && (state_nx == DONE)) begin
        RD_data <= rd_nx;
        mem_err <= err_nx;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: vector table,
// reset-abort sequence and randomized traffic against a model.
module tb_dmem_bus_bridge;

  localparam int T = 8;
`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr_n;
  logic        MemWriteM;
  logic        MemReadM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [3:0]  byteEnable;
  logic [31:0] RD_data;
  logic        StallMem;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rsp_valid;
  logic        bus_rsp_err;
  logic [31:0] bus_rdata;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  dmem_bus_bridge #(
    .TIMEOUT_CYCLES(T),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .MemWriteM(MemWriteM),
    .MemReadM(MemReadM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .byteEnable(byteEnable),
    .RD_data(RD_data),
    .StallMem(StallMem),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_be(bus_be),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_err(bus_rsp_err),
    .bus_rdata(bus_rdata),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          dr;
    int          ds;
    logic [31:0] rdata;
    logic        rerr;
    logic        spur;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    int          e_stall;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  // Stall length and timeout outcome from the access timing rules.
  function automatic void model(input int dr, input int ds,
                                input bit we,
                                output int stall,
                                output bit tmo);
    int r;
    int j;
    tmo = 1'b0;
    if (dr >= T) begin
      stall = 1 + T;
      tmo   = 1'b1;
      return;
    end
    r = dr + 1;
    if (we && POSTED) begin
      stall = 1 + r;
    end else if (ds == 0) begin
      stall = r + 2;
    end else if (r + ds >= T) begin
      j     = (T - r > 1) ? (T - r) : 1;
      stall = 1 + r + j;
      tmo   = 1'b1;
    end else begin
      stall = r + ds + 2;
    end
  endfunction

  task automatic run_txn(input vec_t v, input string nm);
    int  stall;
    int  rq;
    int  wt;
    bit  acc;
    bit  done;
    int  cyc;
    logic [31:0] m;
    @(negedge clk);
    MemWriteM  = v.we;
    MemReadM   = !v.we;
    ALUResultM = v.addr;
    WriteDataM = v.wdata;
    byteEnable = v.be;
    #1;
    stall = 0; rq = 0; wt = 0;
    acc = 1'b0; done = 1'b0; cyc = 0;
    m = {{8{v.e_be[3]}}, {8{v.e_be[2]}},
         {8{v.e_be[1]}}, {8{v.e_be[0]}}};
    while (!done && cyc < 64) begin
      cyc++;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rsp_err   = 1'b0;
      bus_rdata     = $urandom;
      if (!StallMem) begin
        done = 1'b1;
      end else begin
        stall++;
        if (bus_req_valid) begin
          chk({nm, " req"},
              {bus_we, bus_be, bus_addr},
              {v.we, v.e_be, v.e_addr});
          if (v.we) begin
            chk({nm, " wdata"}, bus_wdata & m,
                v.e_wdata & m);
          end
          if (rq == v.dr) begin
            bus_req_ready = 1'b1;
            acc = 1'b1;
            if (v.spur) begin
              bus_rsp_valid = 1'b1;
              bus_rdata     = 32'h1111_1111;
            end
          end
          rq++;
        end else if (acc) begin
          if (wt == v.ds) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_err   = v.rerr;
            bus_rdata     = v.rdata;
          end
          wt++;
        end
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      chk({nm, " budget"}, 64'(cyc), 64'(v.e_stall));
    end else begin
      chk({nm, " stall"}, 64'(stall), 64'(v.e_stall));
      chk({nm, " done"},
          {bus_req_valid, mem_err, RD_data},
          {1'b0, v.e_err, v.e_rd});
    end
    MemWriteM     = 1'b0;
    MemReadM      = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    @(negedge clk);
    #1;
    chk({nm, " after"},
        {StallMem, mem_err, RD_data},
        {1'b0, 1'b0, v.e_rd});
  endtask

  function automatic vec_t mk(input logic we,
                              input logic [31:0] addr,
                              input logic [31:0] wdata,
                              input logic [3:0] be,
                              input int dr, input int ds,
                              input logic [31:0] rdata,
                              input logic rerr,
                              input logic spur,
                              input logic [31:0] e_addr,
                              input logic [31:0] e_wdata,
                              input logic [3:0] e_be,
                              input int e_stall,
                              input logic [31:0] e_rd,
                              input logic e_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.dr = dr; v.ds = ds; v.rdata = rdata; v.rerr = rerr;
    v.spur = spur; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_be = e_be; v.e_stall = e_stall; v.e_rd = e_rd;
    v.e_err = e_err;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   st;
    bit   tmo;
    clr_n         = 1'b0;
    MemWriteM     = 1'b0;
    MemReadM      = 1'b0;
    ALUResultM    = '0;
    WriteDataM    = '0;
    byteEnable    = '0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    bus_rdata     = '0;

    tbl[0] = mk(0, 32'h100, 0, 4'hF, 0, 0, 32'hDEADBEEF, 0, 0,
                32'h100, 0, 4'hF, 3, 32'hDEADBEEF, 0);
    tbl[1] = mk(1, 32'h203, 32'hA5, 4'h8, 0, 0, 0, 0, 0,
                32'h200, 32'hA500_0000, 4'h8,
                POSTED ? 2 : 3, 0, 0);
    tbl[2] = mk(0, 32'h44, 0, 4'h1, 5, 0, 32'h12345678, 0, 0,
                32'h44, 0, 4'hF, 8, 32'h12345678, 0);
    tbl[3] = mk(0, 32'h80, 0, 4'hF, 20, 0, 32'h77, 0, 0,
                32'h80, 0, 4'hF, 9, 0, 1);
    tbl[4] = mk(0, 32'h84, 0, 4'hF, 0, 20, 32'h77, 0, 0,
                32'h84, 0, 4'hF, 9, 0, 1);
    tbl[5] = mk(0, 32'h88, 0, 4'hF, 1, 2, 32'hFFFF0000, 1, 0,
                32'h88, 0, 4'hF, 6, 0, 1);
    tbl[6] = mk(1, 32'h10, 32'hCAFEF00D, 4'hF, 0, 1, 0, 0, 0,
                32'h10, 32'hCAFEF00D, 4'hF,
                POSTED ? 2 : 4, 0, 0);
    tbl[7] = mk(1, 32'h12, 32'h0000BEEF, 4'hC, 2, 0, 0, 1, 0,
                32'h10, 32'hBEEF_0000, 4'hC,
                POSTED ? 4 : 5, 0, !POSTED);
    tbl[8] = mk(0, 32'h3FC, 0, 4'hF, 0, 1, 32'h22222222, 0, 1,
                32'h3FC, 0, 4'hF, 4, 32'h22222222, 0);
    tbl[9] = mk(0, 32'h101, 0, 4'h2, 0, 0, 32'h0A0B0C0D, 0, 0,
                32'h100, 0, 4'hF, 3, 32'h0A0B0C0D, 0);

    @(negedge clk);
    #1;
    chk("reset", {StallMem, bus_req_valid, bus_we, bus_be,
                  bus_addr, mem_err, RD_data},
        '0);
    chk("reset wdata", bus_wdata, '0);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while waiting for a response, then a stale response.
    @(negedge clk);
    MemReadM   = 1'b1;
    ALUResultM = 32'h300;
    #1;
    chk("rst issue stall", StallMem, 1);
    @(negedge clk);
    #1;
    chk("rst req", bus_req_valid, 1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    #1;
    bus_req_ready = 1'b0;
    chk("rst wait stall", StallMem, 1);
    clr_n    = 1'b0;
    MemReadM = 1'b0;
    #1;
    chk("rst abort", {StallMem, bus_req_valid, bus_we, bus_be,
                      bus_addr, mem_err, RD_data},
        '0);
    chk("rst abort wdata", bus_wdata, '0);
    @(negedge clk);
    clr_n         = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rdata     = 32'h5555AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      bus_rsp_valid = 1'b0;
      chk($sformatf("rst stale%0d", i),
          {StallMem, bus_req_valid, mem_err, RD_data}, '0);
    end

    for (int i = 0; i < 40; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.be    = 4'($urandom_range(1, 15));
      v.dr    = $urandom_range(0, 9);
      v.ds    = $urandom_range(0, 9);
      v.rdata = $urandom;
      v.rerr  = ($urandom_range(0, 3) == 0);
      v.spur  = 1'($urandom_range(0, 1));
      model(v.dr, v.ds, v.we, st, tmo);
      v.e_addr  = v.addr & 32'hFFFF_FFFC;
      v.e_wdata = v.wdata << (8 * v.addr[1:0]);
      v.e_be    = v.we ? v.be : 4'hF;
      v.e_stall = st;
      v.e_rd    = (tmo || v.rerr || v.we) ? 32'h0 : v.rdata;
      v.e_err   = tmo || (v.rerr && !(v.we && POSTED));
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
